// File: rtl/bmd_64_pkg.sv
// Shared definitions for the BMD 64-bit DMA engines: one-hot FSM encodings,
// the PCIe 4 KB boundary constant and the TLP length-to-bytes helper.
package bmd_64_pkg;

    typedef enum logic [5:0] {
        ST_IDLE      = 6'b000001,
        ST_LOAD      = 6'b000010,
        ST_REQ       = 6'b000100,
        ST_WAIT_SENT = 6'b001000,
        ST_NEXT      = 6'b010000,
        ST_DONE      = 6'b100000
    } wdma_state_e;

    localparam logic [13:0] BOUNDARY_4K = 14'd4096;

    // A length field of zero means 1024 DWs (4096 bytes).
    function automatic logic [12:0] tlp_bytes(input logic [9:0] len);
        tlp_bytes = (len == 10'd0) ? 13'd4096 : {1'b0, len, 2'b00};
    endfunction

endpackage

// File: rtl/bmd_64_wdma_engine.sv
// Write-DMA engine: walks a frame of memory-write TLPs, handing one header at a
// time to the TX TLP builder and advancing the host address after each send.
module bmd_64_wdma_engine
    import bmd_64_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        init_rst_i,
    input  logic        wdma_start_i,
    input  logic [39:0] wdma_addr_i,
    input  logic [9:0]  mwr_len_i,
    input  logic [15:0] mwr_count_i,
    output logic        wdma_done_o,
    output logic        tlp_req_o,
    input  logic        tlp_ack_i,
    input  logic        tlp_sent_i,
    output logic [39:0] tlp_addr_o,
    output logic [9:0]  tlp_len_o,
    output logic        tlp_64b_o,
    output logic [15:0] tlp_cnt_o,
    output logic        tlp_4k_err_o
);

    wdma_state_e state;
    wdma_state_e state_nxt;

    logic [15:0] count_q;
    logic        soft_rst;
    logic [12:0] step_bytes;
    logic [15:0] cnt_inc;
    logic        cross_4k;

    assign soft_rst   = !rst_n || init_rst_i;
    assign step_bytes = tlp_bytes(tlp_len_o);
    assign cnt_inc    = tlp_cnt_o + 16'd1;
    assign cross_4k   = ({2'b00, tlp_addr_o[11:0]} + {1'b0, step_bytes}) > BOUNDARY_4K;

    assign tlp_req_o  = (state == ST_REQ);
    assign tlp_64b_o  = |tlp_addr_o[39:32];

    always_ff @(posedge clk) begin
        if (soft_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:      if (wdma_start_i) state_nxt = ST_LOAD;
            ST_LOAD:      state_nxt = (mwr_count_i == 16'd0) ? ST_DONE : ST_REQ;
            ST_REQ:       if (tlp_ack_i) state_nxt = ST_WAIT_SENT;
            ST_WAIT_SENT: if (tlp_sent_i) state_nxt = ST_NEXT;
            ST_NEXT:      state_nxt = (cnt_inc == count_q) ? ST_DONE : ST_REQ;
            ST_DONE:      if (!wdma_start_i) state_nxt = ST_IDLE;
            default:      state_nxt = ST_IDLE;
        endcase
    end

    // Frame parameters are captured once in LOAD so later input changes are inert.
    always_ff @(posedge clk) begin
        if (soft_rst) begin
            wdma_done_o  <= 1'b0;
            tlp_addr_o   <= 40'd0;
            tlp_len_o    <= 10'd0;
            tlp_cnt_o    <= 16'd0;
            tlp_4k_err_o <= 1'b0;
            count_q      <= 16'd0;
        end else begin
            wdma_done_o <= (state_nxt == ST_DONE) && (state != ST_DONE);
            case (state)
                ST_LOAD: begin
                    tlp_addr_o <= wdma_addr_i;
                    tlp_len_o  <= mwr_len_i;
                    count_q    <= mwr_count_i;
                    tlp_cnt_o  <= 16'd0;
                end
                ST_REQ: begin
                    if (cross_4k) tlp_4k_err_o <= 1'b1;
                end
                ST_NEXT: begin
                    tlp_addr_o <= tlp_addr_o + {27'd0, step_bytes};
                    tlp_cnt_o  <= cnt_inc;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bmd_64_wdma_engine.sv
// Self-checking bench for bmd_64_wdma_engine: table-driven frames plus directed
// sequences for zero-count frames and soft reset in the middle of a frame.
module tb_bmd_64_wdma_engine;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        init_rst_i;
    logic        wdma_start_i;
    logic [39:0] wdma_addr_i;
    logic [9:0]  mwr_len_i;
    logic [15:0] mwr_count_i;
    logic        wdma_done_o;
    logic        tlp_req_o;
    logic        tlp_ack_i;
    logic        tlp_sent_i;
    logic [39:0] tlp_addr_o;
    logic [9:0]  tlp_len_o;
    logic        tlp_64b_o;
    logic [15:0] tlp_cnt_o;
    logic        tlp_4k_err_o;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    bmd_64_wdma_engine dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .init_rst_i   (init_rst_i),
        .wdma_start_i (wdma_start_i),
        .wdma_addr_i  (wdma_addr_i),
        .mwr_len_i    (mwr_len_i),
        .mwr_count_i  (mwr_count_i),
        .wdma_done_o  (wdma_done_o),
        .tlp_req_o    (tlp_req_o),
        .tlp_ack_i    (tlp_ack_i),
        .tlp_sent_i   (tlp_sent_i),
        .tlp_addr_o   (tlp_addr_o),
        .tlp_len_o    (tlp_len_o),
        .tlp_64b_o    (tlp_64b_o),
        .tlp_cnt_o    (tlp_cnt_o),
        .tlp_4k_err_o (tlp_4k_err_o)
    );

    typedef struct {
        logic [39:0] addr;
        logic [9:0]  len;
        logic [15:0] count;
        bit          drop_early;
        int          exp_n;
        logic [39:0] exp_first;
        logic [39:0] exp_last;
        logic        exp_64_first;
        logic        exp_64_last;
        logic        exp_err;
    } vec_t;

    vec_t vecs[5];

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
        end
    endtask

    task automatic softReset();
        @(negedge clk);
        init_rst_i = 1'b1;
        @(negedge clk);
        init_rst_i = 1'b0;
    endtask

    // Runs one frame, acting as the TX builder, and checks everything observed.
    task automatic applyStimulus(input vec_t v, input int idx);
        int          n_tlps = 0;
        int          n_done = 0;
        int          req_age = 0;
        int          sent_cd = -1;
        int          post = -1;
        bit          stable_ok = 1'b1;
        bit          drop_ok = 1'b1;
        bit          finished = 1'b0;
        logic [39:0] first_a = '0;
        logic [39:0] cur_a = '0;
        logic        f64 = 1'b0;
        logic        l64 = 1'b0;
        logic [15:0] cnt_at_done = '0;
        string       tag;
        tag = $sformatf("v%0d", idx);
        softReset();
        wdma_addr_i  = v.addr;
        mwr_len_i    = v.len;
        mwr_count_i  = v.count;
        wdma_start_i = 1'b1;
        for (int cyc = 0; cyc < 600 && !finished; cyc++) begin
            @(negedge clk);
            tlp_ack_i  = 1'b0;
            tlp_sent_i = 1'b0;
            if (wdma_done_o) begin
                n_done++;
                if (n_done == 1) begin
                    cnt_at_done = tlp_cnt_o;
                    post = 0;
                end
            end
            if (tlp_req_o) begin
                if (req_age == 0) begin
                    n_tlps++;
                    cur_a = tlp_addr_o;
                    if (n_tlps == 1) begin
                        first_a = tlp_addr_o;
                        f64 = tlp_64b_o;
                        wdma_addr_i = 40'hA5_5A5A_5A5A;
                        mwr_len_i   = 10'd7;
                        mwr_count_i = 16'd9;
                        if (v.drop_early) wdma_start_i = 1'b0;
                    end
                    l64 = tlp_64b_o;
                end else if (tlp_addr_o !== cur_a) begin
                    stable_ok = 1'b0;
                end
                if (tlp_len_o !== v.len) stable_ok = 1'b0;
                if (req_age == 1) tlp_sent_i = 1'b1;
                if (req_age == 2) begin
                    tlp_ack_i = 1'b1;
                    sent_cd = 2;
                end
                if (req_age >= 3) drop_ok = 1'b0;
                req_age++;
            end else begin
                req_age = 0;
                if (sent_cd > 0) sent_cd--;
                else if (sent_cd == 0) begin
                    tlp_sent_i = 1'b1;
                    sent_cd = -1;
                end
            end
            if (post >= 0) begin
                if (post == 10) wdma_start_i = 1'b0;
                if (post == 13) finished = 1'b1;
                post++;
            end
        end
        tlp_ack_i = 1'b0;
        tlp_sent_i = 1'b0;
        wdma_start_i = 1'b0;
        checkOutput({tag, "_timeout"}, {63'd0, finished}, 64'd1);
        checkOutput({tag, "_tlps"}, n_tlps, v.exp_n);
        checkOutput({tag, "_done_pulses"}, n_done, 1);
        checkOutput({tag, "_first_addr"}, first_a, v.exp_first);
        checkOutput({tag, "_last_addr"}, cur_a, v.exp_last);
        checkOutput({tag, "_64b_first"}, f64, v.exp_64_first);
        checkOutput({tag, "_64b_last"}, l64, v.exp_64_last);
        checkOutput({tag, "_req_stable"}, stable_ok, 1);
        checkOutput({tag, "_req_drop"}, drop_ok, 1);
        checkOutput({tag, "_cnt_at_done"}, cnt_at_done, v.exp_n);
        checkOutput({tag, "_4k_err_sticky"}, tlp_4k_err_o, v.exp_err);
    endtask

    task automatic waitReq(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (tlp_req_o) ok = 1'b1;
        end
    endtask

    initial begin
        bit ok;
        int seen_done;
        int seen_req;

        vecs[0] = '{40'h00_1000_0000, 10'd32, 16'd4, 1'b0, 4, 40'h00_1000_0000, 40'h00_1000_0180, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{40'hFF_FFFF_FF80, 10'd32, 16'd2, 1'b0, 2, 40'hFF_FFFF_FF80, 40'h00_0000_0000, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{40'h00_0000_0F80, 10'd64, 16'd1, 1'b0, 1, 40'h00_0000_0F80, 40'h00_0000_0F80, 1'b0, 1'b0, 1'b1};
        vecs[3] = '{40'h00_2000_0000, 10'd0,  16'd3, 1'b1, 3, 40'h00_2000_0000, 40'h00_2000_2000, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{40'h01_0000_0004, 10'd0,  16'd1, 1'b0, 1, 40'h01_0000_0004, 40'h01_0000_0004, 1'b1, 1'b1, 1'b1};

        rst_n = 1'b0;
        init_rst_i = 1'b0;
        wdma_start_i = 1'b0;
        wdma_addr_i = 40'hFF_FFFF_FFFF;
        mwr_len_i = 10'h3FF;
        mwr_count_i = 16'hFFFF;
        tlp_ack_i = 1'b0;
        tlp_sent_i = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("rst_done", wdma_done_o, 0);
        checkOutput("rst_req", tlp_req_o, 0);
        checkOutput("rst_err", tlp_4k_err_o, 0);
        checkOutput("rst_addr", tlp_addr_o, 0);
        checkOutput("rst_len", tlp_len_o, 0);
        checkOutput("rst_cnt", tlp_cnt_o, 0);

        for (int i = 0; i < 5; i++) applyStimulus(vecs[i], i);

        // Zero-count frame: done two cycles after start, then held start must not retrigger.
        softReset();
        mwr_count_i = 16'd0;
        wdma_addr_i = 40'h00_0000_1000;
        mwr_len_i = 10'd32;
        wdma_start_i = 1'b1;
        @(negedge clk);
        checkOutput("cnt0_done_early", wdma_done_o, 0);
        @(negedge clk);
        checkOutput("cnt0_done_pulse", wdma_done_o, 1);
        seen_done = 0;
        seen_req = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (wdma_done_o) seen_done++;
            if (tlp_req_o) seen_req++;
        end
        checkOutput("cnt0_no_retrigger", seen_done, 0);
        checkOutput("cnt0_no_req", seen_req, 0);
        wdma_start_i = 1'b0;
        repeat (2) @(negedge clk);

        // Soft reset while TLP 2 of 4 waits for its sent pulse.
        softReset();
        wdma_addr_i = 40'h00_0000_1000;
        mwr_len_i = 10'd32;
        mwr_count_i = 16'd4;
        wdma_start_i = 1'b1;
        waitReq(ok);
        checkOutput("abort_req1", ok, 1);
        tlp_ack_i = 1'b1;
        @(negedge clk);
        tlp_ack_i = 1'b0;
        tlp_sent_i = 1'b1;
        @(negedge clk);
        tlp_sent_i = 1'b0;
        waitReq(ok);
        checkOutput("abort_req2", ok, 1);
        checkOutput("abort_addr2", tlp_addr_o, 40'h00_0000_1080);
        tlp_ack_i = 1'b1;
        @(negedge clk);
        tlp_ack_i = 1'b0;
        init_rst_i = 1'b1;
        wdma_start_i = 1'b0;
        @(negedge clk);
        init_rst_i = 1'b0;
        tlp_sent_i = 1'b1;
        @(negedge clk);
        tlp_sent_i = 1'b0;
        seen_done = 0;
        seen_req = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (wdma_done_o) seen_done++;
            if (tlp_req_o) seen_req++;
        end
        checkOutput("abort_no_done", seen_done, 0);
        checkOutput("abort_no_req", seen_req, 0);
        checkOutput("abort_cnt", tlp_cnt_o, 0);
        checkOutput("abort_addr", tlp_addr_o, 0);
        applyStimulus(vecs[0], 5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
